// File: rtl/hazard_forward_unit.sv
// Hazard-detection and operand-forwarding unit beside decode/register-fetch.
// Tracks destinations of in-flight instructions, picks forwarded operands, and stalls on load-use.
module hazard_forward_unit #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int DATA_WIDTH     = 64,
    parameter int FWD_DEPTH      = 2,
    parameter int ZERO_REG_EN    = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            id_valid,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rs1,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rs2,
    input  logic                            id_rs1_used,
    input  logic                            id_rs2_used,
    input  logic [REG_ADDR_WIDTH-1:0]       id_rd,
    input  logic                            id_wr_en,
    input  logic                            id_is_load,
    input  logic                            flush,
    input  logic [DATA_WIDTH-1:0]           rf_data1,
    input  logic [DATA_WIDTH-1:0]           rf_data2,
    input  logic [FWD_DEPTH*DATA_WIDTH-1:0] stage_data,
    output logic                            stall,
    output logic [2:0]                      fwd_sel1,
    output logic [2:0]                      fwd_sel2,
    output logic [DATA_WIDTH-1:0]           op_data1,
    output logic [DATA_WIDTH-1:0]           op_data2,
    output logic [CNT_WIDTH-1:0]            stall_count
);

    logic [FWD_DEPTH-1:0]      ent_valid;
    logic [FWD_DEPTH-1:0]      ent_wr_en;
    logic [FWD_DEPTH-1:0]      ent_is_load;
    logic [REG_ADDR_WIDTH-1:0] ent_rd [FWD_DEPTH];

    logic rs1_zero;
    logic rs2_zero;
    logic accept;

    assign rs1_zero = (ZERO_REG_EN != 0) && (id_rs1 == '0);
    assign rs2_zero = (ZERO_REG_EN != 0) && (id_rs2 == '0);

    // Scan oldest to youngest so the youngest matching entry overwrites the select.
    always_comb begin
        fwd_sel1 = '0;
        fwd_sel2 = '0;
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (ent_valid[k] && ent_wr_en[k] && ent_rd[k] == id_rs1 && id_rs1_used && !rs1_zero)
                fwd_sel1 = 3'(k + 1);
            if (ent_valid[k] && ent_wr_en[k] && ent_rd[k] == id_rs2 && id_rs2_used && !rs2_zero)
                fwd_sel2 = 3'(k + 1);
        end
    end

    always_comb begin
        op_data1 = rf_data1;
        op_data2 = rf_data2;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            if (fwd_sel1 == 3'(k + 1))
                op_data1 = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (fwd_sel2 == 3'(k + 1))
                op_data2 = stage_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Load data only exists from entry 1 onward, so a youngest match in entry 0 must wait a cycle.
    assign stall  = id_valid && !flush && ent_is_load[0] && (fwd_sel1 == 3'd1 || fwd_sel2 == 3'd1);
    assign accept = id_valid && !stall && !flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid   <= '0;
            ent_wr_en   <= '0;
            ent_is_load <= '0;
            for (int k = 0; k < FWD_DEPTH; k++)
                ent_rd[k] <= '0;
        end else begin
            for (int k = 1; k < FWD_DEPTH; k++) begin
                ent_valid[k]   <= ent_valid[k-1];
                ent_wr_en[k]   <= ent_wr_en[k-1];
                ent_is_load[k] <= ent_is_load[k-1];
                ent_rd[k]      <= ent_rd[k-1];
            end
            ent_valid[0]   <= accept;
            ent_wr_en[0]   <= accept && id_wr_en;
            ent_is_load[0] <= accept && id_is_load;
            ent_rd[0]      <= id_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall && stall_count != '1)
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed vector table, saturation sequence, and randomized
// traffic against an in-flight history model, on a depth-2 and a depth-1 instance.
module tb_hazard_forward_unit;

    logic         clk;
    logic         reset;
    logic         id_valid;
    logic [4:0]   id_rs1, id_rs2, id_rd;
    logic         id_rs1_used, id_rs2_used, id_wr_en, id_is_load, flush;
    logic [63:0]  rf_data1, rf_data2;
    logic [127:0] sd;

    logic         st2, st1;
    logic [2:0]   s1_2, s2_2, s1_1, s2_1;
    logic [63:0]  o1_2, o2_2, o1_1, o2_1;
    logic [3:0]   cnt2;
    logic [15:0]  cnt1;

    int checks   = 0;
    int failures = 0;

    hazard_forward_unit #(.FWD_DEPTH(2), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_data(sd),
        .stall(st2), .fwd_sel1(s1_2), .fwd_sel2(s2_2), .op_data1(o1_2), .op_data2(o2_2),
        .stall_count(cnt2)
    );

    hazard_forward_unit #(.FWD_DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
        .id_wr_en(id_wr_en), .id_is_load(id_is_load), .flush(flush),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .stage_data(sd[63:0]),
        .stall(st1), .fwd_sel1(s1_1), .fwd_sel2(s2_1), .op_data1(o1_1), .op_data2(o2_1),
        .stall_count(cnt1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic drive(input logic r, input logic v, input logic [4:0] a1, input logic u1,
                         input logic [4:0] a2, input logic u2, input logic [4:0] d,
                         input logic w, input logic l, input logic f);
        reset = r; id_valid = v; id_rs1 = a1; id_rs1_used = u1; id_rs2 = a2; id_rs2_used = u2;
        id_rd = d; id_wr_en = w; id_is_load = l; flush = f;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // directed vector table
    typedef struct {
        logic rst, vld; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
        logic [4:0] rd; logic wr, ld, fl;
        logic chk_ops, e_stall; logic [2:0] e_sel1, e_sel2; logic [63:0] e_op1, e_op2;
        logic [3:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic rst, logic vld, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic [4:0] rd, logic wr, logic ld, logic fl,
                                logic c, logic es, logic [2:0] e1, logic [2:0] e2,
                                logic [63:0] eo1, logic [63:0] eo2, logic [3:0] ec);
        vec_t v;
        v.rst = rst; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2; v.rd = rd;
        v.wr = wr; v.ld = ld; v.fl = fl; v.chk_ops = c; v.e_stall = es; v.e_sel1 = e1;
        v.e_sel2 = e2; v.e_op1 = eo1; v.e_op2 = eo2; v.e_cnt = ec;
        return v;
    endfunction

    // scoreboard: history of post-decode instructions, youngest first
    typedef struct packed { logic v; logic [4:0] rd; logic wr; logic ld; } trk_t;
    trk_t hist[$];
    logic [63:0] exp_q[$];
    int m_cnt2, m_cnt1;

    function automatic int youngest(int depth, logic [4:0] s, logic used);
        if (!used || s == 5'd0) return -1;
        for (int k = 0; k < depth && k < hist.size(); k++)
            if (hist[k].v && hist[k].wr && hist[k].rd == s) return k;
        return -1;
    endfunction

    function automatic logic model_stall(int i1, int i2);
        return id_valid && !flush && hist.size() > 0 && hist[0].ld && (i1 == 0 || i2 == 0);
    endfunction

    task automatic check_dut(input string tag, input int depth, input logic a_st,
                             input logic [2:0] a_s1, input logic [2:0] a_s2,
                             input logic [63:0] a_o1, input logic [63:0] a_o2,
                             input int a_cnt, input int e_cnt);
        int i1, i2;
        logic es;
        i1 = youngest(depth, id_rs1, id_rs1_used);
        i2 = youngest(depth, id_rs2, id_rs2_used);
        es = model_stall(i1, i2);
        chk({tag, " stall"}, 64'(a_st), 64'(es));
        chk({tag, " stall_count"}, 64'(a_cnt), 64'(e_cnt));
        if (!(es && i1 == 0)) begin
            exp_q.push_back(i1 < 0 ? rf_data1 : sd[i1*64 +: 64]);
            chk({tag, " fwd_sel1"}, 64'(a_s1), 64'(i1 + 1));
            chk({tag, " op_data1"}, a_o1, exp_q.pop_front());
        end
        if (!(es && i2 == 0)) begin
            exp_q.push_back(i2 < 0 ? rf_data2 : sd[i2*64 +: 64]);
            chk({tag, " fwd_sel2"}, 64'(a_s2), 64'(i2 + 1));
            chk({tag, " op_data2"}, a_o2, exp_q.pop_front());
        end
    endtask

    vec_t vecs[17];

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rf_data1 = 64'hAAAA;
        rf_data2 = 64'hBBBB;
        sd = {64'hBEEF, 64'h1234};

        //             rst vld rs1 u1 rs2 u2 rd wr ld fl  chk st s1 s2 op1      op2      cnt
        vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 0);
        vecs[1]  = mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 0);
        vecs[2]  = mk(0, 1, 3, 1, 0, 0, 3, 1, 0, 0, 1, 0, 1, 0, 64'h1234, 64'hBBBB, 0);
        vecs[3]  = mk(0, 1, 3, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 64'h1234, 64'hBBBB, 0);
        vecs[4]  = mk(0, 1, 3, 1, 0, 0, 5, 1, 1, 0, 1, 0, 2, 0, 64'hBEEF, 64'hBBBB, 0);
        vecs[5]  = mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 64'h0,    64'h0,    0);
        vecs[6]  = mk(0, 1, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 2, 64'hAAAA, 64'hBEEF, 1);
        vecs[7]  = mk(0, 1, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[8]  = mk(0, 1, 0, 0, 5, 1, 5, 1, 0, 1, 1, 0, 0, 1, 64'hAAAA, 64'h1234, 1);
        vecs[9]  = mk(0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 1, 0, 0, 2, 64'hAAAA, 64'hBEEF, 1);
        vecs[10] = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[11] = mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[12] = mk(0, 1, 0, 1, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[13] = mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[14] = mk(0, 1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 1);
        vecs[15] = mk(1, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 0);
        vecs[16] = mk(0, 1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 64'hAAAA, 64'hBBBB, 0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].vld, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2,
                  vecs[i].rd, vecs[i].wr, vecs[i].ld, vecs[i].fl);
            #1;
            chk($sformatf("vec%0d stall", i), 64'(st2), 64'(vecs[i].e_stall));
            chk($sformatf("vec%0d stall_count", i), 64'(cnt2), 64'(vecs[i].e_cnt));
            if (vecs[i].chk_ops) begin
                chk($sformatf("vec%0d fwd_sel1", i), 64'(s1_2), 64'(vecs[i].e_sel1));
                chk($sformatf("vec%0d fwd_sel2", i), 64'(s2_2), 64'(vecs[i].e_sel2));
                chk($sformatf("vec%0d op_data1", i), o1_2, vecs[i].e_op1);
                chk($sformatf("vec%0d op_data2", i), o2_2, vecs[i].e_op2);
            end
        end

        // 20 load-use stalls: 4-bit counter saturates, 16-bit counter reaches 20
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive(0, 1, 0, 0, 0, 0, 5, 1, 1, 0);
            @(negedge clk);
            drive(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
            #1;
            chk($sformatf("sat%0d stall d2", n), 64'(st2), 64'd1);
            chk($sformatf("sat%0d stall d1", n), 64'(st1), 64'd1);
            @(negedge clk);
            drive(0, 1, 0, 0, 5, 1, 0, 0, 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("saturated stall_count d2", 64'(cnt2), 64'd15);
        chk("stall_count d1", 64'(cnt1), 64'd20);

        // randomized traffic against the history model
        hist.delete();
        m_cnt2 = 0;
        m_cnt1 = 0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            logic r, v, w, l, f, es;
            logic [4:0] d;
            @(negedge clk);
            r = ($urandom_range(0, 99) < 2);
            v = ($urandom_range(0, 9) < 8);
            w = ($urandom_range(0, 9) < 7);
            l = ($urandom_range(0, 9) < 3);
            f = ($urandom_range(0, 9) < 1);
            d = 5'($urandom_range(0, 3));
            drive(r, v, 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), d, w, l, f);
            rf_data1 = {$urandom, $urandom};
            rf_data2 = {$urandom, $urandom};
            sd = {$urandom, $urandom, $urandom, $urandom};
            if (r) begin
                hist.delete();
                m_cnt2 = 0;
                m_cnt1 = 0;
            end
            #1;
            check_dut($sformatf("rnd%0d d2", c), 2, st2, s1_2, s2_2, o1_2, o2_2, int'(cnt2), m_cnt2);
            check_dut($sformatf("rnd%0d d1", c), 1, st1, s1_1, s2_1, o1_1, o2_1, int'(cnt1), m_cnt1);
            es = model_stall(youngest(2, id_rs1, id_rs1_used), youngest(2, id_rs2, id_rs2_used));
            if (!r) begin
                hist.push_front('{v: (v && !es && !f), rd: d, wr: w, ld: l});
                if (hist.size() > 7) void'(hist.pop_back());
                if (es) begin
                    m_cnt2 = (m_cnt2 == 15) ? 15 : m_cnt2 + 1;
                    m_cnt1 = (m_cnt1 == 65535) ? 65535 : m_cnt1 + 1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
